// File: rtl/bitwise_slice_unit.sv
// Multi-cycle eight-operation bitwise unit: processes a WIDTH-bit operand pair SLICE bits per cycle.
// Define LOGIC_SLICE_FLAGS_EN to add the registered zr/ng result flags.
module bitwise_slice_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
`ifdef LOGIC_SLICE_FLAGS_EN
   ,
   output logic             zr,
   output logic             ng
`endif
);

   localparam int unsigned N  = WIDTH / SLICE;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LastIdx = CW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]       op_q, op_d;
   logic [SLICE-1:0] slice_a, slice_b, slice_r;

`ifdef LOGIC_SLICE_FLAGS_EN
   logic zr_q, zr_d, ng_q, ng_d;
`endif

   always_comb begin
      slice_a = a_q[cnt_q*SLICE +: SLICE];
      slice_b = b_q[cnt_q*SLICE +: SLICE];
      slice_r = slice_a;
      unique case (op_q)
         3'd0: slice_r = ~slice_a;
         3'd1: slice_r = slice_a & slice_b;
         3'd2: slice_r = slice_a | slice_b;
         3'd3: slice_r = slice_a ^ slice_b;
         3'd4: slice_r = ~(slice_a & slice_b);
         3'd5: slice_r = ~(slice_a | slice_b);
         3'd6: slice_r = ~(slice_a ^ slice_b);
         3'd7: slice_r = slice_a;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
`ifdef LOGIC_SLICE_FLAGS_EN
      zr_d    = zr_q;
      ng_d    = ng_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               cnt_d   = '0;
               res_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            res_d[cnt_q*SLICE +: SLICE] = slice_r;
            if (cnt_q == LastIdx) begin
               state_d = StDone;
`ifdef LOGIC_SLICE_FLAGS_EN
               // Flags follow the fully assembled result, not the previous one
               zr_d    = (res_d == '0);
               ng_d    = res_d[WIDTH-1];
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
`ifdef LOGIC_SLICE_FLAGS_EN
         zr_q    <= 1'b1;
         ng_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
`ifdef LOGIC_SLICE_FLAGS_EN
         zr_q    <= zr_d;
         ng_q    <= ng_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q == StRun) || (state_q == StDone);
   assign out_data  = res_q;
`ifdef LOGIC_SLICE_FLAGS_EN
   assign zr        = zr_q;
   assign ng        = ng_q;
`endif

endmodule

// File: tb/tb_bitwise_slice_unit.sv
// Directed bench for bitwise_slice_unit: instance 0 uses SLICE=4, instances 1 and 2 use
// SLICE=16 and SLICE=1 for the latency corners.
module tb_bitwise_slice_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  op;
   logic [15:0] a, b;
   logic [2:0]  in_valid, in_ready, out_valid, out_ready, busy;
   logic [15:0] od [3];
`ifdef LOGIC_SLICE_FLAGS_EN
   logic [2:0]  zr, ng;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   bitwise_slice_unit #(.WIDTH(16), .SLICE(4)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op),
      .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od[0]),
      .busy(busy[0])
`ifdef LOGIC_SLICE_FLAGS_EN
      , .zr(zr[0]), .ng(ng[0])
`endif
   );

   bitwise_slice_unit #(.WIDTH(16), .SLICE(16)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op),
      .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od[1]),
      .busy(busy[1])
`ifdef LOGIC_SLICE_FLAGS_EN
      , .zr(zr[1]), .ng(ng[1])
`endif
   );

   bitwise_slice_unit #(.WIDTH(16), .SLICE(1)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .op(op),
      .a(a), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od[2]),
      .busy(busy[2])
`ifdef LOGIC_SLICE_FLAGS_EN
      , .zr(zr[2]), .ng(ng[2])
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one request on instance idx, check latency and result, then complete the handshake.
   task automatic run_txn(input int idx, input logic [2:0] o, input logic [15:0] va,
                          input logic [15:0] vb, input int lat, input logic [15:0] exp);
      int cyc;
      op = o; a = va; b = vb;
      check_eq("in_ready_before_accept", 32'(in_ready[idx]), 32'd1);
      in_valid[idx] = 1'b1;
      tick();
      in_valid[idx] = 1'b0;
      op = ~o; a = ~va; b = ~vb;
      check_eq("busy_after_accept", 32'(busy[idx]), 32'd1);
      cyc = 0;
      while (!out_valid[idx] && cyc < 40) begin
         tick();
         cyc++;
      end
      check_eq($sformatf("latency_i%0d_op%0d", idx, o), 32'(cyc), 32'(lat));
      check_eq($sformatf("data_i%0d_op%0d", idx, o), 32'(od[idx]), 32'(exp));
      out_ready[idx] = 1'b1;
      tick();
      out_ready[idx] = 1'b0;
      check_eq("idle_after_handshake", {29'd0, in_ready[idx], out_valid[idx], busy[idx]}, 32'b100);
      check_eq("data_held_after_done", 32'(od[idx]), 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] sweep_exp [8];
      logic        saw_valid;
      sweep_exp = '{16'h0000, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};

      reset_n = 1'b0; in_valid = '0; out_ready = '0; op = '0; a = '0; b = '0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
      check_eq("rst_busy", 32'(busy[0]), 32'd0);
      check_eq("rst_out_data", 32'(od[0]), 32'h0000);
`ifdef LOGIC_SLICE_FLAGS_EN
      check_eq("rst_zr", 32'(zr[0]), 32'd1);
      check_eq("rst_ng", 32'(ng[0]), 32'd0);
`endif

      run_txn(0, 3'd0, 16'h00FF, 16'hABCD, 4, 16'hFF00);
`ifdef LOGIC_SLICE_FLAGS_EN
      check_eq("not_zr", 32'(zr[0]), 32'd0);
      check_eq("not_ng", 32'(ng[0]), 32'd1);
`endif

      for (int o = 1; o < 8; o++) run_txn(0, 3'(o), 16'hF0F0, 16'hFF00, 4, sweep_exp[o]);

      // Back-pressure: result must stay put while new requests are presented
      op = 3'd3; a = 16'hF0F0; b = 16'hFF00;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 10; i++) begin
         op = 3'(i); a = 16'(i * 16'h1111); b = ~a;
         in_valid[0] = i[0];
         check_eq("bp_out_valid", 32'(out_valid[0]), 32'd1);
         check_eq("bp_out_data", 32'(od[0]), 32'h0FF0);
         check_eq("bp_in_ready", 32'(in_ready[0]), 32'd0);
         tick();
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      check_eq("bp_released", {30'd0, in_ready[0], out_valid[0]}, 32'b10);

      // Reset while slice 2 is being written
      op = 3'd1; a = 16'hFFFF; b = 16'hFFFF;
      saw_valid = 1'b0;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      saw_valid |= out_valid[0];
      tick();
      saw_valid |= out_valid[0];
      reset_n = 1'b0;
      tick();
      saw_valid |= out_valid[0];
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         saw_valid |= out_valid[0];
         tick();
      end
      check_eq("rr_no_valid", 32'(saw_valid), 32'd0);
      check_eq("rr_in_ready", 32'(in_ready[0]), 32'd1);
      check_eq("rr_out_data", 32'(od[0]), 32'h0000);

      run_txn(1, 3'd6, 16'h1234, 16'h1234, 1, 16'hFFFF);
`ifdef LOGIC_SLICE_FLAGS_EN
      check_eq("s16_zr", 32'(zr[1]), 32'd0);
      check_eq("s16_ng", 32'(ng[1]), 32'd1);
`endif
      run_txn(2, 3'd6, 16'h1234, 16'h1234, 16, 16'hFFFF);
`ifdef LOGIC_SLICE_FLAGS_EN
      check_eq("s1_zr", 32'(zr[2]), 32'd0);
      check_eq("s1_ng", 32'(ng[2]), 32'd1);
`endif
      run_txn(2, 3'd2, 16'hA5A5, 16'h0F0F, 16, 16'hAFAF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bitwise_slice_unit.md
# bitwise_slice_unit

Parametrised, multi-cycle bitwise logic unit that generalises the 16-bit inverter into an eight-operation engine with configurable width and slice size. It processes a WIDTH-bit operand pair SLICE bits per clock, using an FSM with valid/ready handshakes on both sides. It sits between the Hack CPU datapath and any register-file or memory client that needs registered bitwise results with back-pressure.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a positive multiple of SLICE
- SLICE, 4, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept; high only in IDLE
- op  input  3  0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS a
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; ignored for ops 0 and 7
- out_valid  output  1  result held valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- busy  output  1  high in RUN or DONE
- zr, ng  output  1 each  present only with LOGIC_SLICE_FLAGS_EN (see Configuration)

## Operation
- N = WIDTH/SLICE slices; slice counter is ceil(log2(N)) bits wide, minimum 1.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, register a, b, op; clear counter and result; go to RUN.
- RUN: each cycle, compute slice k (bits k*SLICE+SLICE-1 : k*SLICE) from the captured operands and write it into the result register, LSB slice first. When k = N-1, write the final slice and go to DONE; otherwise increment k.
- DONE: out_valid=1, out_data stable. On out_ready, go to IDLE.
- Input port changes after acceptance have no effect on the transaction in flight.
- out_data holds the last result after leaving DONE until the next acceptance clears it. Only out_valid qualifies it.
- All 8 op codes are legal; there is no error path.

## Timing
- Reset (reset_n low at a clk edge): state=IDLE, counter=0, result=0. After reset: in_ready=1, out_valid=0, busy=0, out_data=0, zr=1, ng=0.
- Reset mid-RUN or mid-DONE: the transaction is discarded and no out_valid is produced.
- Latency: accept at edge T, out_valid high after edge T+N. For N=1, out_valid is high the cycle after acceptance.
- out_ready may be high before out_valid. The handshake completes on the first edge where both are high.
- Throughput: one transaction per N+2 cycles minimum. in_ready is low in the cycle in which DONE completes; there is no accept in the same cycle as a result handshake.
- in_valid while busy is ignored; the request must be held by the producer.
- out_ready deasserted in DONE: stay in DONE indefinitely, with outputs stable.

## Configuration
- LOGIC_SLICE_FLAGS_EN defined:
  - Adds outputs zr and ng, registered alongside the result.
  - zr = (result == 0) and ng = result[WIDTH-1], updated on the final slice write.
  - Both are valid whenever out_valid=1.
- LOGIC_SLICE_FLAGS_EN undefined:
  - zr and ng are absent from the port list.
  - No flag logic is synthesised.
  - All other behaviour is identical.

## Test plan
- Reset/idle: hold reset_n=0 for 2 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_data=0x0000.
- Basic NOT (WIDTH=16, SLICE=4): accept op=0, a=0x00FF -> out_valid exactly 4 cycles after accept, out_data=0xFF00. With flags: zr=0, ng=1.
- Op sweep: a=0xF0F0, b=0xFF00, ops 1..7 -> 0xF000, 0xFFF0, 0x0FF0, 0x0FFF, 0x000F, 0xF00F, 0xF0F0.
- Back-pressure: keep out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready stays 0. Pulsing in_valid with new operands during this time does not change the result.
- Reset mid-RUN: accept op=1, then assert reset_n=0 at slice 2 -> after reset, in IDLE with out_valid never having pulsed and out_data=0.
- Parameter corners: run WIDTH=16, SLICE=16 (latency 1) and SLICE=1 (latency 16) with op=6, a=b=0x1234 -> out_data=0xFFFF. With flags: zr=0, ng=1.
